// File: rtl/spi_slave_handler_pkg.sv
// Shared command codes, upload source tags and helpers for the SPI blocks.
package spi_slave_handler_pkg;

  // SPI master command codes and upload tag
  localparam logic [7:0] CMD_SPI_MASTER_CFG    = 8'h10;
  localparam logic [7:0] CMD_SPI_MASTER_XFER   = 8'h11;
  localparam logic [7:0] UPLOAD_SRC_SPI_MASTER = 8'h03;

  // SPI slave command code and upload tag
  localparam logic [7:0] CMD_SPI_SLAVE_PRELOAD = 8'h14;
  localparam logic [7:0] UPLOAD_SRC_SPI_SLAVE  = 8'h04;

  // Transmit buffer capacity in bytes
  localparam logic [8:0] TX_BUF_BYTES = 9'd256;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } cmd_state_e;

  // Clamp a command payload length to the transmit buffer size.
  function automatic logic [8:0] clamp_tx_len(input logic [15:0] len);
    if (len > 16'd256) begin
      return TX_BUF_BYTES;
    end else begin
      return len[8:0];
    end
  endfunction

  // Advance the transmit pointer, holding at the buffer size.
  function automatic logic [8:0] sat_inc_ptr(input logic [8:0] ptr);
    if (ptr == TX_BUF_BYTES) begin
      return ptr;
    end else begin
      return ptr + 9'd1;
    end
  endfunction

endpackage

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave physical layer: input synchronizers, edge detection,
// MOSI byte assembly and MISO byte serialisation (MSB first).
module spi_slave_phy (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic [7:0] tx_byte,
  output logic       spi_miso,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       cs_fall,
  output logic       cs_high,
  output logic       cs_high_next
);

  logic       sck_meta_r, sck_sync_r, sck_prev_r;
  logic       cs_meta_r, cs_sync_r, cs_prev_r;
  logic       mosi_meta_r, mosi_sync_r;
  logic [1:0] settle_r;
  logic       armed_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] rx_shift_r;
  logic [6:0] tx_shift_r;
  logic       miso_r;
  logic       rx_valid_r;
  logic [7:0] rx_data_r;

  logic       sck_rise_s, sck_fall_s, cs_fall_s, active_s;

  // Edge and activity decode on synchronized values; the block only acts
  // once it has seen a genuine idle-high chip select since reset.
  always_comb begin
    sck_rise_s = sck_sync_r & ~sck_prev_r;
    sck_fall_s = ~sck_sync_r & sck_prev_r;
    cs_fall_s  = armed_r & ~cs_sync_r & cs_prev_r;
    active_s   = armed_r & ~cs_sync_r;
  end

  // Two-flop synchronizers plus previous-value flops, idle levels at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_r  <= 1'b0;
      sck_sync_r  <= 1'b0;
      sck_prev_r  <= 1'b0;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      sck_meta_r  <= spi_clk;
      sck_sync_r  <= sck_meta_r;
      sck_prev_r  <= sck_sync_r;
      cs_meta_r   <= spi_cs_n;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
      mosi_meta_r <= spi_mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  // Arm only after the synchronizers hold real samples and cs_n is high, so a
  // reset taken mid-frame waits for the next true cs_n falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_r <= 2'd0;
      armed_r  <= 1'b0;
    end else begin
      if (settle_r != 2'd3) begin
        settle_r <= settle_r + 2'd1;
      end
      if ((settle_r == 2'd3) && cs_sync_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Shift engine: sample MOSI on SCK rise, drive MISO on SCK fall and at
  // frame start; a completed byte is flagged for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 7'd0;
      tx_shift_r <= 7'h7F;
      miso_r     <= 1'b1;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
    end else if (!active_s) begin
      bit_cnt_r  <= 3'd0;
      tx_shift_r <= 7'h7F;
      miso_r     <= 1'b1;
      rx_valid_r <= 1'b0;
    end else if (cs_fall_s) begin
      bit_cnt_r  <= 3'd0;
      miso_r     <= tx_byte[7];
      tx_shift_r <= tx_byte[6:0];
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (sck_rise_s) begin
        rx_shift_r <= {rx_shift_r[5:0], mosi_sync_r};
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          rx_valid_r <= 1'b1;
          rx_data_r  <= {rx_shift_r, mosi_sync_r};
        end
      end else if (sck_fall_s) begin
        if (bit_cnt_r == 3'd0) begin
          miso_r     <= tx_byte[7];
          tx_shift_r <= tx_byte[6:0];
        end else begin
          miso_r     <= tx_shift_r[6];
          tx_shift_r <= {tx_shift_r[5:0], 1'b1};
        end
      end
    end
  end

  assign spi_miso     = miso_r;
  assign rx_valid     = rx_valid_r;
  assign rx_data      = rx_data_r;
  assign cs_fall      = cs_fall_s;
  assign cs_high      = cs_sync_r;
  assign cs_high_next = cs_meta_r;

endmodule

// File: rtl/spi_slave_handler.sv
// SPI slave handler: preload command FSM filling the MISO buffer, received
// byte FIFO and upload stream towards the host.
module spi_slave_handler #(
  parameter logic [7:0] CMD_SPI_SLAVE_PRELOAD = spi_slave_handler_pkg::CMD_SPI_SLAVE_PRELOAD,
  parameter logic [7:0] UPLOAD_SRC_SPI_SLAVE  = spi_slave_handler_pkg::UPLOAD_SRC_SPI_SLAVE,
  parameter int         RX_FIFO_DEPTH         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_type,
  input  logic [15:0] cmd_length,
  input  logic [7:0]  cmd_data,
  input  logic [15:0] cmd_data_index,
  input  logic        cmd_data_valid,
  input  logic        cmd_start,
  input  logic        cmd_done,
  output logic        cmd_ready,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        upload_req,
  output logic [7:0]  upload_data,
  output logic [7:0]  upload_source,
  output logic        upload_valid,
  input  logic        upload_ready,
  output logic        rx_overflow
);

  import spi_slave_handler_pkg::*;

  localparam int              AW       = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT = RX_FIFO_DEPTH[AW:0];
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1'b1);

  cmd_state_e  state_r, state_next_s;
  logic        cmd_ready_r, cmd_ready_next_s, accept_s;
  logic [8:0]  tx_len_r, tx_ptr_r;
  logic [7:0]  tx_buf_r [0:255];
  logic [7:0]  tx_byte_s;

  logic [7:0]  fifo_mem_r [0:RX_FIFO_DEPTH-1];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0] count_r, count_next_s;
  logic        push_s, pop_s, drop_s, full_s;
  logic        overflow_r;
  logic        upload_req_r, upload_valid_r;
  logic [7:0]  upload_data_r, upload_source_r;

  logic        rx_valid_s, cs_fall_s, cs_high_s, cs_high_next_s;
  logic [7:0]  rx_data_s;

  spi_slave_phy u_phy (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_clk      (spi_clk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .tx_byte      (tx_byte_s),
    .spi_miso     (spi_miso),
    .rx_valid     (rx_valid_s),
    .rx_data      (rx_data_s),
    .cs_fall      (cs_fall_s),
    .cs_high      (cs_high_s),
    .cs_high_next (cs_high_next_s)
  );

  // Command FSM next state; a preload is only taken while cmd_ready is shown.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_start && (cmd_type == CMD_SPI_SLAVE_PRELOAD) && cmd_ready_r) begin
          state_next_s = ST_LOAD;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cmd_done) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
    cmd_ready_next_s = (state_next_s == ST_LOAD) | cs_high_next_s;
  end

  // Command FSM state, registered cmd_ready and latched transmit length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      tx_len_r    <= 9'd0;
    end else begin
      state_r     <= state_next_s;
      cmd_ready_r <= cmd_ready_next_s;
      if (accept_s) begin
        tx_len_r <= clamp_tx_len(cmd_length);
      end
    end
  end

  // Payload bytes land in the transmit buffer; indices past the buffer drop.
  always_ff @(posedge clk) begin
    if ((state_r == ST_LOAD) && cmd_data_valid && (cmd_data_index < 16'd256)) begin
      tx_buf_r[cmd_data_index[7:0]] <= cmd_data;
    end
  end

  // Byte offered to the shifter: buffered data inside tx_len, else all ones.
  always_comb begin
    if (tx_ptr_r < tx_len_r) begin
      tx_byte_s = tx_buf_r[tx_ptr_r[7:0]];
    end else begin
      tx_byte_s = 8'hFF;
    end
  end

  // Transmit pointer: rewound while deselected, advances per completed byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ptr_r <= 9'd0;
    end else if (cs_high_s || cs_fall_s) begin
      tx_ptr_r <= 9'd0;
    end else if (rx_valid_s) begin
      tx_ptr_r <= sat_inc_ptr(tx_ptr_r);
    end
  end

  // FIFO control: a pop frees room for a same-cycle push when full.
  always_comb begin
    full_s       = (count_r == FULL_CNT);
    pop_s        = upload_ready & (count_r != '0);
    push_s       = rx_valid_s & (~full_s | pop_s);
    drop_s       = rx_valid_s & full_s & ~pop_s;
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, written on every accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= rx_data_s;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the upload handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
      overflow_r      <= 1'b0;
      upload_req_r    <= 1'b0;
      upload_valid_r  <= 1'b0;
      upload_data_r   <= 8'h00;
      upload_source_r <= 8'h00;
    end else begin
      count_r        <= count_next_s;
      upload_req_r   <= (count_next_s != '0);
      upload_valid_r <= pop_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r        <= rd_ptr_r + PTR_ONE;
        upload_data_r   <= fifo_mem_r[rd_ptr_r];
        upload_source_r <= UPLOAD_SRC_SPI_SLAVE;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (accept_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign upload_req    = upload_req_r;
  assign upload_valid  = upload_valid_r;
  assign upload_data   = upload_data_r;
  assign upload_source = upload_source_r;
  assign rx_overflow   = overflow_r;

endmodule

// File: tb/tb_spi_slave_handler.sv
// Directed bench for spi_slave_handler: acts as SPI master and command source.
module tb_spi_slave_handler;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_data_index;
  logic        cmd_data_valid, cmd_start, cmd_done, cmd_ready;
  logic        spi_clk, spi_cs_n, spi_mosi, spi_miso;
  logic        upload_req, upload_valid, upload_ready, rx_overflow;
  logic [7:0]  upload_data, upload_source;

  int checks   = 0;
  int failures = 0;

  logic [15:0] up_q [$];
  logic [7:0]  mo_v [0:31];
  logic [7:0]  mi_v [0:31];
  logic [15:0] pl_idx [0:7];
  logic [7:0]  pl_dat [0:7];
  logic [7:0]  mi_b;

  always #5 clk = ~clk;

  spi_slave_handler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_type       (cmd_type),
    .cmd_length     (cmd_length),
    .cmd_data       (cmd_data),
    .cmd_data_index (cmd_data_index),
    .cmd_data_valid (cmd_data_valid),
    .cmd_start      (cmd_start),
    .cmd_done       (cmd_done),
    .cmd_ready      (cmd_ready),
    .spi_clk        (spi_clk),
    .spi_cs_n       (spi_cs_n),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .upload_req     (upload_req),
    .upload_data    (upload_data),
    .upload_source  (upload_source),
    .upload_valid   (upload_valid),
    .upload_ready   (upload_ready),
    .rx_overflow    (rx_overflow)
  );

  // Collect every upload beat as {source, data}.
  always @(negedge clk) begin
    if (upload_valid === 1'b1) up_q.push_back({upload_source, upload_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic spi_xfer_byte(input logic [7:0] mo, output logic [7:0] mi);
    for (int b = 7; b >= 0; b--) begin
      spi_mosi = mo[b];
      #HALF;
      spi_clk = 1'b1;
      mi[b] = spi_miso;
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int n);
    spi_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < n; i++) begin
      spi_xfer_byte(mo_v[i], mi_b);
      mi_v[i] = mi_b;
    end
    #HALF;
    spi_cs_n = 1'b1;
    #(HALF * 2);
  endtask

  task automatic preload(input logic [7:0] typ, input logic [15:0] len, input int n);
    @(negedge clk);
    cmd_type = typ; cmd_length = len; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      cmd_data = pl_dat[i]; cmd_data_index = pl_idx[i]; cmd_data_valid = 1'b1;
      @(negedge clk);
    end
    cmd_data_valid = 1'b0;
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_type = 8'h00; cmd_length = 16'd0; cmd_data = 8'h00;
    cmd_data_index = 16'd0; cmd_data_valid = 1'b0; cmd_start = 1'b0; cmd_done = 1'b0;
    spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; upload_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_upload_req", upload_req, 0);
    check("rst_upload_valid", upload_valid, 0);
    check("rst_upload_data", upload_data, 0);
    check("rst_upload_source", upload_source, 0);
    check("rst_overflow", rx_overflow, 0);
    check("rst_miso", spi_miso, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic preload and 3-byte exchange
    upload_ready = 1'b1;
    pl_idx[0] = 16'd0; pl_dat[0] = 8'hA5;
    pl_idx[1] = 16'd1; pl_dat[1] = 8'h3C;
    preload(8'h14, 16'd2, 2);
    check("pre_cmd_ready", cmd_ready, 1);
    mo_v[0] = 8'h11; mo_v[1] = 8'h22; mo_v[2] = 8'h33;
    spi_frame(3);
    check("basic_miso0", mi_v[0], 8'hA5);
    check("basic_miso1", mi_v[1], 8'h3C);
    check("basic_miso2", mi_v[2], 8'hFF);
    repeat (20) @(negedge clk);
    check("basic_up_count", up_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("basic_up%0d", i), up_q[i], {8'h04, mo_v[i]});
    up_q.delete();

    // Aborted partial byte, then a fresh frame starting at tx_buf[0]
    spi_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'b1; #HALF; spi_clk = 1'b1; #HALF; spi_clk = 1'b0;
    end
    #HALF;
    spi_cs_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_up_count", up_q.size(), 0);
    check("abort_upload_req", upload_req, 0);
    check("abort_miso_idle", spi_miso, 1);
    mo_v[0] = 8'h55;
    spi_frame(1);
    check("abort_next_miso", mi_v[0], 8'hA5);
    repeat (10) @(negedge clk);
    check("abort_next_count", up_q.size(), 1);
    check("abort_next_up", up_q[0], 16'h0455);
    up_q.delete();

    // Preload while selected is refused and leaves tx_buf alone
    spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_cmd_ready", cmd_ready, 0);
    pl_dat[0] = 8'h00; pl_dat[1] = 8'h00;
    preload(8'h14, 16'd2, 2);
    check("busy_cmd_ready_after", cmd_ready, 0);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_cmd_ready_back", cmd_ready, 1);
    mo_v[0] = 8'h66; mo_v[1] = 8'h77;
    spi_frame(2);
    check("busy_miso0", mi_v[0], 8'hA5);
    check("busy_miso1", mi_v[1], 8'h3C);
    repeat (10) @(negedge clk);
    up_q.delete();

    // 17 bytes with no grant: 16 kept, overflow set
    upload_ready = 1'b0;
    for (int i = 0; i < 17; i++) mo_v[i] = 8'(i + 1);
    spi_frame(17);
    check("ovf_miso0", mi_v[0], 8'hA5);
    check("ovf_miso2", mi_v[2], 8'hFF);
    check("ovf_miso16", mi_v[16], 8'hFF);
    check("ovf_flag", rx_overflow, 1);
    check("ovf_upload_req", upload_req, 1);
    check("ovf_no_upload", up_q.size(), 0);
    upload_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("ovf_up_count", up_q.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("ovf_up%0d", i), up_q[i], {8'h04, 8'(i + 1)});
    check("ovf_drained_req", upload_req, 0);
    check("ovf_flag_sticky", rx_overflow, 1);
    up_q.delete();
    preload(8'h14, 16'd0, 0);
    check("ovf_cleared", rx_overflow, 0);
    mo_v[0] = 8'h01; mo_v[1] = 8'h02;
    spi_frame(2);
    check("len0_miso0", mi_v[0], 8'hFF);
    check("len0_miso1", mi_v[1], 8'hFF);
    repeat (10) @(negedge clk);
    up_q.delete();

    // Long length clamps to the buffer; index 256 must not alias index 0
    pl_idx[0] = 16'd0;   pl_dat[0] = 8'h5A;
    pl_idx[1] = 16'd256; pl_dat[1] = 8'h00;
    preload(8'h14, 16'd300, 2);
    spi_frame(2);
    check("clamp_miso0", mi_v[0], 8'h5A);
    check("clamp_miso1", mi_v[1], 8'h3C);
    repeat (10) @(negedge clk);
    up_q.delete();

    // Reset taken mid-byte with data waiting in the FIFO
    upload_ready = 1'b0;
    spi_cs_n = 1'b0;
    #HALF;
    spi_xfer_byte(8'h99, mi_b);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b0; #HALF; spi_clk = 1'b1; #HALF; spi_clk = 1'b0;
    end
    #HALF;
    spi_clk = 1'b1;
    #20;
    check("mid_pre_req", upload_req, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", upload_req, 0);
    check("mid_rst_valid", upload_valid, 0);
    check("mid_rst_data", upload_data, 0);
    check("mid_rst_source", upload_source, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_overflow", rx_overflow, 0);
    check("mid_rst_miso", spi_miso, 1);
    #30;
    rst_n = 1'b1;
    spi_clk = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_post_ready", cmd_ready, 0);
    check("mid_post_miso", spi_miso, 1);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    upload_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_fifo_empty", up_q.size(), 0);
    mo_v[0] = 8'h42;
    spi_frame(1);
    check("mid_txlen_reset", mi_v[0], 8'hFF);
    repeat (10) @(negedge clk);
    check("mid_up_count", up_q.size(), 1);
    check("mid_up0", up_q[0], 16'h0442);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
